div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Sequential restoring divider; the inverse operation to the team's hierarchical array multiplier.
- Computes quotient and remainder of two WIDTH-bit unsigned operands, one quotient bit per clock.
- Built from a chain of 1-bit restoring subtract cells.
- Uses a start/busy/done handshake toward a controlling FSM or testbench.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x  input  WIDTH  dividend, sampled on the start edge
- y  input  WIDTH  divisor, sampled on the start edge
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- busy  output  1  high while state != IDLE
- done  output  1  single-cycle pulse; q/r/dz valid
- dz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: state=IDLE; q=0, r=0, busy=0, done=0, dz=0; internal counter and registers cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1, y!=0, at edge N:
  - latch x into quotient shift register and y into divisor register; clear partial remainder; counter=WIDTH-1; go to RUN.
- IDLE, start=1, y==0, at edge N:
  - go straight to DONE; q=all ones, r=x, dz=1.
- RUN, each edge (one iteration):
  - shift {rem, quo} left by 1.
  - trial = rem_shifted - divisor, WIDTH+1 bits wide.
  - if trial is non-negative: rem=trial[WIDTH-1:0], quo[0]=1; else restore rem, quo[0]=0.
  - counter decrements; at counter==0 the iteration completes and state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: WIDTH iterations occupy edges N+1..N+WIDTH; done is high in the cycle after edge N+WIDTH. For divide-by-zero, done is high in the cycle after edge N.
- q and r update only on entry to DONE and hold until the next DONE. dz updates on the same edge and holds likewise.
- start while busy=1 (RUN or DONE) is ignored and not queued. start may be held high continuously; a new operation begins at the first IDLE edge.
- x and y may change freely after the start edge without effect.
- Reset mid-operation: immediate return to IDLE; outputs revert to reset values; no done pulse.
- Invariant for every non-zero divisor: x == q*y + r, with r < y.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: x, y, q and r are two's complement.
  - Operands are converted to magnitudes on the start edge; the unsigned core runs unchanged.
  - Signs are fixed on entry to DONE: quotient negated if signs differ (truncation toward zero); remainder takes the sign of the dividend.
  - Divide-by-zero: q=all ones, r=x, dz=1.
  - Most-negative / -1 overflow: q=most-negative, r=0; dz stays 0.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Package div_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the DIV_W default width constant.
- Sub-module res1b: 1-bit restoring subtract cell.
  - Inputs: a, b, borrow_in, sel. Outputs: borrow_out, diff.
  - Instantiated WIDTH+1 times in a generate chain to form the trial subtractor and restore mux.
  - Mirrors the 1-bit cell structure of the multiplier.

Test Plan:
- WIDTH=4, x=13, y=3, start pulse -> done after 4 RUN cycles; q=4, r=1, dz=0; busy high for 5 cycles.
- x=15, y=1 -> q=15, r=0. x=2, y=5 -> q=0, r=2.
- x=7, y=0 -> done in the cycle after the start edge; q=4'hF, r=7, dz=1. Next op x=9, y=2 -> q=4, r=1, dz=0.
- start held high for 20 cycles with x=12, y=4 -> back-to-back ops, each done pulse one cycle wide, q=3, r=0 each time; start pulses during RUN produce no extra done.
- rst asserted asynchronously mid-RUN (between edges) -> outputs zero immediately, state IDLE, no done; a following op 10/3 gives q=3, r=1.
- With DIV_SIGNED_EN defined:
  - -7/2 -> q=4'b1101, r=4'b1111.
  - 7/-2 -> q=4'b1101, r=1.
  - -8/-1 -> q=4'b1000, r=0, dz=0.
- Random sweep of all 256 WIDTH=4 operand pairs, checked against the x==q*y+r invariant.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider (div_seq).
package div_pkg;

  localparam int unsigned DIV_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/res1b.sv
// 1-bit restoring subtract cell: a - b - borrow_in, or a unchanged when sel is low (restore).
module res1b (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  input  logic sel,
  output logic borrow_out,
  output logic diff
);

  logic sub;

  always_comb begin
    sub        = a ^ b ^ borrow_in;
    borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    diff       = sel ? sub : a;
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] mag_x, mag_y;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Trial subtraction of the divisor from the shifted partial remainder (WIDTH+1 bits).
  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic [WIDTH+1:0] borrow;
  logic             trial_ok;
  logic             unused_diff_msb;

  assign trial_a   = {rem_q, quo_q[WIDTH-1]};
  assign trial_b   = {1'b0, div_q};
  assign borrow[0] = 1'b0;
  assign trial_ok  = ~borrow[WIDTH+1];

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    res1b u_cell (
      .a          (trial_a[i]),
      .b          (trial_b[i]),
      .borrow_in  (borrow[i]),
      .sel        (trial_ok),
      .borrow_out (borrow[i+1]),
      .diff       (trial_diff[i])
    );
  end

  // Result always fits WIDTH bits: either below the divisor or restored from a smaller value.
  assign unused_diff_msb = trial_diff[WIDTH];
  assign rem_nxt         = trial_diff[WIDTH-1:0];
  assign quo_nxt         = {quo_q[WIDTH-2:0], trial_ok};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign mag_x = x[WIDTH-1] ? -x : x;
  assign mag_y = y[WIDTH-1] ? -y : y;
  assign q_fix = negq_q ? -quo_nxt : quo_nxt;
  assign r_fix = negr_q ? -rem_nxt : rem_nxt;

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == ST_IDLE && start) begin
      negq_d = x[WIDTH-1] ^ y[WIDTH-1];
      negr_d = x[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign mag_x = x;
  assign mag_y = y;
  assign q_fix = quo_nxt;
  assign r_fix = rem_nxt;
`endif

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (y == '0) begin
            state_d = ST_DONE;
            q_d     = '1;
            r_d     = x;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
            quo_d   = mag_x;
            div_d   = mag_y;
            rem_d   = '0;
            cnt_d   = CntW'(WIDTH - 1);
          end
        end
      end
      ST_RUN: begin
        quo_d = quo_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          q_d     = q_fix;
          r_d     = r_fix;
          dz_d    = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, handshake corner cases, full operand sweep.
module tb_div_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [W-1:0] q, r;
  logic         busy, done, dz;

  int n_vec = 0;
  int n_err = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic edz);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    edz = 1'b0;
    if (b == '0) begin
      eq = '1; er = a; edz = 1'b1;
    end else if (sa == -(1 << (W - 1)) && sb == -1) begin
      eq = W'(1 << (W - 1)); er = '0;
    end else begin
      eq = W'(sa / sb); er = W'(sa % sb);
    end
`else
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    edz = 1'b0;
    if (ub == 0) begin
      eq = '1; er = a; edz = 1'b1;
    end else begin
      eq = W'(ua / ub); er = W'(ua % ub);
    end
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] oq, output logic [W-1:0] orr,
                       output logic odz, output int lat);
    start = 1'b1; x = a; y = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0; x = W'($urandom); y = W'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 50) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    oq = q; orr = r; odz = dz;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    logic [W-1:0] aq, ar;
    logic         adz;
    int           lat;
    do_op(a, b, aq, ar, adz, lat);
    chk({name, ".q"}, 32'(aq), 32'(eq));
    chk({name, ".r"}, 32'(ar), 32'(er));
    chk({name, ".dz"}, 32'(adz), 32'(edz));
    chk({name, ".lat"}, 32'(lat), edz ? 32'd1 : 32'(W + 1));
    chk({name, ".done_width"}, 32'(done), 32'd0);
`ifndef DIV_SIGNED_EN
    if (b != '0) begin
      chk({name, ".invariant"}, 32'(int'(aq) * int'(b) + int'(ar)), 32'(a));
      chk({name, ".r_lt_y"}, 32'(ar < b), 32'd1);
    end
`endif
  endtask

  initial begin
    logic [W-1:0] eq, er, aq, ar;
    logic         edz, adz, prev_done;
    int           cnt, lat, mult, off, idx;

`ifdef DIV_SIGNED_EN
    tbl.push_back('{4'd9,  4'd2,  4'hD, 4'hF, 1'b0});
    tbl.push_back('{4'd7,  4'hE,  4'hD, 4'd1, 1'b0});
    tbl.push_back('{4'd8,  4'hF,  4'h8, 4'd0, 1'b0});
    tbl.push_back('{4'd7,  4'd0,  4'hF, 4'd7, 1'b1});
    tbl.push_back('{4'hD,  4'd3,  4'hF, 4'd0, 1'b0});
    tbl.push_back('{4'd6,  4'hD,  4'hE, 4'd0, 1'b0});
    tbl.push_back('{4'hF,  4'd2,  4'd0, 4'hF, 1'b0});
`else
    tbl.push_back('{4'd13, 4'd3,  4'd4,  4'd1,  1'b0});
    tbl.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0});
    tbl.push_back('{4'd2,  4'd5,  4'd0,  4'd2,  1'b0});
    tbl.push_back('{4'd7,  4'd0,  4'hF,  4'd7,  1'b1});
    tbl.push_back('{4'd9,  4'd2,  4'd4,  4'd1,  1'b0});
    tbl.push_back('{4'd10, 4'd3,  4'd3,  4'd1,  1'b0});
    tbl.push_back('{4'd0,  4'd7,  4'd0,  4'd0,  1'b0});
    tbl.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
    tbl.push_back('{4'd14, 4'd15, 4'd0,  4'd14, 1'b0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.q", 32'(q), 32'd0);
    chk("rst.r", 32'(r), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dz", 32'(dz), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].eq,
                               tbl[i].er, tbl[i].edz);

    // Busy spans the RUN iterations plus the DONE cycle
    start = 1'b1; x = 4'd13; y = 4'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    chk("busy_cycles", 32'(cnt), 32'(W + 1));
    model(4'd13, 4'd3, eq, er, edz);
    chk("busy_op.q", 32'(q), 32'(eq));

    // Start held high: back-to-back operations, one-cycle done pulses
    model(4'd12, 4'd4, eq, er, edz);
    start = 1'b1; x = 4'd12; y = 4'd4;
    cnt = 0;
    prev_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) begin
        cnt++;
        chk("held.q", 32'(q), 32'(eq));
        chk("held.r", 32'(r), 32'(er));
        chk("held.pulse", 32'(prev_done), 32'd0);
      end
      prev_done = done;
    end
    chk("held.done_count", 32'(cnt), 32'd3);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    chk("held.drain", 32'(busy), 32'd0);

    // Asynchronous reset between edges during RUN
    start = 1'b1; x = 4'd11; y = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.q", 32'(q), 32'd0);
    chk("arst.r", 32'(r), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("arst.no_done", 32'(cnt), 32'd0);
    model(4'd10, 4'd3, eq, er, edz);
    run_check("arst_next", 4'd10, 4'd3, eq, er, edz);

    // All 256 operand pairs in a random order
    mult = int'($urandom) | 1;
    off  = int'($urandom);
    for (int i = 0; i < 256; i++) begin
      idx = (i * mult + off) & 255;
      model(W'(idx >> 4), W'(idx), eq, er, edz);
      do_op(W'(idx >> 4), W'(idx), aq, ar, adz, lat);
      n_vec++;
      if (aq !== eq || ar !== er || adz !== edz || lat != (edz ? 1 : W + 1)) begin
        n_err++;
        $display("FAIL sweep %0d/%0d: got q=%0h r=%0h dz=%0b lat=%0d expected q=%0h r=%0h dz=%0b",
                 idx >> 4, idx & 15, aq, ar, adz, lat, eq, er, edz);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
